// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
//   IMEM_BASE_ADDR : byte address of word 0 (matches fetch-stage reset PC)
//   IMEM_WORD_W    : instruction word width
//   imem_state_e   : responder FSM states
package imem_pkg;

  localparam logic [31:0] IMEM_BASE_ADDR = 32'h0100_0000;
  localparam int unsigned IMEM_WORD_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_resp_if.sv
// Fetch-side bus between the fetch stage (master) and imem_resp (slave).
//   req_valid/req_ready : request handshake
//   req_write           : 1 = write req_wdata, 0 = read
//   req_addr/req_wdata  : byte address / write data
//   rsp_valid/rsp_ready : response handshake
//   rsp_data            : returned instruction word
//   rsp_err             : error flag, present only with IMEM_RESP_ERR_EN
interface imem_resp_if;
  import imem_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [31:0]            req_addr;
  logic [IMEM_WORD_W-1:0] req_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IMEM_WORD_W-1:0] rsp_data;
`ifdef IMEM_RESP_ERR_EN
  logic                   rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
`else
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
`endif
endinterface

// File: rtl/imem_array.sv
// Instruction storage: DEPTH_WORDS x 32, one write port, one registered read port.
//   clock    : rising-edge clock
//   we_i     : write enable, waddr_i/wdata_i : write index / data
//   re_i     : read enable,  raddr_i         : read index
//   rdata_o  : read data, updated only on re_i and held otherwise
// Contents are not reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                   clock,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       waddr_i,
  input  logic [IMEM_WORD_W-1:0] wdata_i,
  input  logic                   re_i,
  input  logic [IDX_W-1:0]       raddr_i,
  output logic [IMEM_WORD_W-1:0] rdata_o
);

  logic [IMEM_WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [IMEM_WORD_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_resp.sv
// Instruction-memory responder: accepts word reads/writes from the fetch
// stage over a valid/ready bus and returns read data after LATENCY cycles.
//   clock : rising-edge clock
//   reset : synchronous, active-high; aborts any pending read
//   bus   : imem_resp_if.slave (request/response handshakes)
// Optional feature macro: IMEM_RESP_ERR_EN adds rsp_err, flags out-of-range
// or misaligned reads and drops misaligned writes.
module imem_resp
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IMEM_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  imem_resp_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  imem_state_e            state_q;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic [3:0]             cnt_q;
  logic                   ok_q;

  logic [31:0]            off;
  logic                   in_range;
  logic                   req_ok;
  logic [IDX_W-1:0]       idx;
  logic                   accept;
  logic                   wr_en;
  logic                   rd_en;
  logic [IMEM_WORD_W-1:0] rdata;

  // Subtract first and compare the word offset, so addresses below BASE_ADDR
  // (which wrap to huge offsets) are rejected by the lower-bound term.
  always_comb begin
    off      = bus.req_addr - BASE_ADDR;
    in_range = (bus.req_addr >= BASE_ADDR) && ((off >> 2) < 32'(DEPTH_WORDS));
    idx      = off[IDX_W+1:2];
`ifdef IMEM_RESP_ERR_EN
    req_ok   = in_range && (bus.req_addr[1:0] == 2'b00);
`else
    req_ok   = in_range;
`endif
  end

  logic unused_off_lsb;
  assign unused_off_lsb = ^{off[1:0], off[31:IDX_W+2]};

  assign accept = bus.req_valid && req_ready_q;
  assign wr_en  = accept && bus.req_write && req_ok && !reset;
  assign rd_en  = accept && !bus.req_write;

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clock   (clock),
    .we_i    (wr_en),
    .waddr_i (idx),
    .wdata_i (bus.req_wdata),
    .re_i    (rd_en),
    .raddr_i (idx),
    .rdata_o (rdata)
  );

  // Counter is loaded with LATENCY-1 and RESP is entered on the edge that
  // takes it from 1 to 0, giving rsp_valid exactly LATENCY cycles after accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
      ok_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_en) begin
            ok_q        <= req_ok;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= BUSY;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (cnt_q <= 4'd1) begin
            state_q     <= RESP;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array read register holds its value until the next accepted read, so
  // gating it here keeps rsp_data stable through RESP and zero otherwise.
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = (rsp_valid_q && ok_q) ? rdata : '0;
`ifdef IMEM_RESP_ERR_EN
  assign bus.rsp_err   = rsp_valid_q && !ok_q;
`endif

endmodule

// File: tb/tb_imem_resp.sv
// Directed, scoreboard-based bench for imem_resp (LATENCY=2, DEPTH_WORDS=1024).
// Honours IMEM_RESP_ERR_EN when defined.
module tb_imem_resp;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
`ifdef IMEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_resp_if bus();

  imem_resp #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] model [DEPTH];
  logic [32:0] exp_q [$];   // {err, data}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    longint unsigned la = 64'(a);
    longint unsigned lb = 64'(BASE);
    return (la >= lb) && ((la - lb) < 64'(4 * DEPTH));
  endfunction

  function automatic logic [32:0] expect_rd(input logic [31:0] a);
    bit bad;
    logic [31:0] w;
    bad = !addr_ok(a) || (ERR_EN && (a[1:0] != 2'b00));
    w = a - BASE;
    if (bad) return {ERR_EN, 32'h0};
    return {1'b0, model[w[11:2]]};
  endfunction

  task automatic wait_ready(input string tag);
    int unsigned t = 0;
    while (bus.req_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk(tag, {31'h0, bus.req_ready}, 32'h1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    @(negedge clk);
    wait_ready("wr_ready_timeout");
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    w = a - BASE;
    if (addr_ok(a) && !(ERR_EN && a[1:0] != 2'b00)) model[w[11:2]] = d;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input int unsigned hold);
    int unsigned lat = 0;
    logic [32:0] e;
    logic [31:0] first_data;
    @(negedge clk);
    wait_ready({tag, "_ready_timeout"});
    exp_q.push_back(expect_rd(a));
    bus.rsp_ready = (hold == 0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.rsp_valid !== 1'b1 && lat < 20);
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_req_ready_low"}, {31'h0, bus.req_ready}, 32'h0);
    e = exp_q.pop_front();
    chk({tag, "_data"}, bus.rsp_data, e[31:0]);
`ifdef IMEM_RESP_ERR_EN
    chk({tag, "_err"}, {31'h0, bus.rsp_err}, {31'h0, e[32]});
`endif
    first_data = bus.rsp_data;
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
      chk({tag, "_hold_data"}, bus.rsp_data, first_data);
      chk({tag, "_hold_req_ready"}, {31'h0, bus.req_ready}, 32'h0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, {31'h0, bus.rsp_valid}, 32'h0);
    chk({tag, "_idle_ready"}, {31'h0, bus.req_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
`ifdef IMEM_RESP_ERR_EN
    chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
`endif

    // 1: write then read back word 0
    do_write(BASE, 32'h0050_0093);
    @(negedge clk);
    chk("wr_stays_ready", {31'h0, bus.req_ready}, 32'h1);
    do_read("t1", BASE, 0);

    // 3 prep: back-to-back writes of words 1..15 and the top word
    for (int unsigned i = 1; i < 16; i++)
      do_write(BASE + 32'(4 * i), 32'hA500_0000 + 32'(i * 32'h0101_0101));
    do_write(BASE + 32'(4 * (DEPTH - 1)), 32'hCAFE_F00D);

    // 2: response held for 5 cycles with rsp_ready low
    do_read("t2", BASE + 32'd8, 5);

    // 3: sixteen sequential reads
    for (int unsigned i = 0; i < 16; i++)
      do_read($sformatf("t3_%0d", i), BASE + 32'(4 * i), 0);

    // 4: out-of-range writes must not alias into storage, reads return 0
    do_write(32'h00FF_FFFC, 32'hDEAD_0001);
    do_write(BASE + 32'(4 * DEPTH), 32'hDEAD_0002);
    do_read("t4_below", 32'h00FF_FFFC, 0);
    do_read("t4_above", BASE + 32'(4 * DEPTH), 0);
    do_read("t4_top", BASE + 32'(4 * (DEPTH - 1)), 0);
    do_read("t4_w0", BASE, 0);

    // 5: reset while BUSY aborts the read
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = BASE + 32'd4;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_valid", {31'h0, bus.rsp_valid}, 32'h0);
      chk("t5_ready", {31'h0, bus.req_ready}, 32'h1);
    end
    do_read("t5_after", BASE + 32'd4, 0);
    do_read("t5_w0", BASE, 0);

    // 6: misaligned read and misaligned write
    do_read("t6_misalign", BASE + 32'd2, 0);
    do_write(BASE + 32'd6, 32'h1234_5678);
    do_read("t6_after_mw", BASE + 32'd4, 0);

    // write-then-read of a fresh value
    do_write(BASE + 32'd12, 32'h0BAD_BEEF);
    do_read("raw", BASE + 32'd12, 0);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
